vid_gen_axil_regs: RTL

AXI4-Lite responder (slave) register bank for the vid_gen IP. It answers the single-beat write and read transactions the PS/VIP master issues on S00_AXI. It holds four 32-bit R/W configuration registers plus a read-only status register, and drives decoded control fields to the video timing/pattern core.

---
 rtl/vid_gen_axil_pkg.sv | 72 +++++++
 rtl/vid_gen_axil_wr_ctrl.sv | 92 +++++++++
 rtl/vid_gen_axil_regs.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vid_gen_axil_pkg.sv
// vid_gen_axil_pkg: shared definitions for the vid_gen AXI4-Lite register bank.
//   Register offsets/indices, AXI response codes, FSM state enums, reset values,
//   the write-commit request struct and small address-decode helpers.
//   Optional feature macro: VID_GEN_IRQ_EN (adds IRQ_EN / IRQ_STAT registers).
package vid_gen_axil_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    // Byte offsets
    localparam logic [4:0] ADDR_CTRL     = 5'h00;
    localparam logic [4:0] ADDR_HSIZE    = 5'h04;
    localparam logic [4:0] ADDR_VSIZE    = 5'h08;
    localparam logic [4:0] ADDR_COLOR    = 5'h0C;
    localparam logic [4:0] ADDR_STATUS   = 5'h10;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'h14;
    localparam logic [4:0] ADDR_IRQ_STAT = 5'h18;

    // Word indices (addr[4:2])
    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_HSIZE    = 3'd1;
    localparam logic [2:0] IDX_VSIZE    = 3'd2;
    localparam logic [2:0] IDX_COLOR    = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;
    localparam logic [2:0] IDX_IRQ_EN   = 3'd5;
    localparam logic [2:0] IDX_IRQ_STAT = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [DATA_W-1:0] RST_CTRL  = '0;
    localparam logic [DATA_W-1:0] RST_HSIZE = '0;
    localparam logic [DATA_W-1:0] RST_VSIZE = '0;
    localparam logic [DATA_W-1:0] RST_COLOR = '0;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    typedef struct packed {
        logic [2:0]        idx;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_commit_t;

    // Word index answers OKAY (anything else gets SLVERR).
    function automatic logic idx_decoded(input logic [2:0] idx);
`ifdef VID_GEN_IRQ_EN
        return idx <= IDX_IRQ_STAT;
`else
        return idx <= IDX_STATUS;
`endif
    endfunction

    // Word index is a plain R/W configuration register (drives cfg_update).
    function automatic logic idx_cfg(input logic [2:0] idx);
`ifdef VID_GEN_IRQ_EN
        return (idx <= IDX_COLOR) || (idx == IDX_IRQ_EN);
`else
        return idx <= IDX_COLOR;
`endif
    endfunction

endpackage

// File: rtl/vid_gen_axil_wr_ctrl.sv
// vid_gen_axil_wr_ctrl: AXI4-Lite write channel FSM.
//   Accepts AW and W independently (either order), latches whichever arrives
//   first, and on the second handshake issues a one-cycle commit with the word
//   index, data and byte strobes. Holds B until BREADY; one write outstanding.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   aw_* / w_* / b_*  AXI4-Lite AW, W, B channel signals
//   commit            combinational strobe: register bank writes on this edge
//   commit_req        word index / data / strobes of the committing write
import vid_gen_axil_pkg::*;

module vid_gen_axil_wr_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    input  logic              w_valid,
    output logic              w_ready,
    output logic [1:0]        b_resp,
    output logic              b_valid,
    input  logic              b_ready,
    output logic              commit,
    output wr_commit_t        commit_req
);

    wr_state_t         state, state_nxt;
    logic [2:0]        a_idx_q;
    logic [DATA_W-1:0] d_data_q;
    logic [STRB_W-1:0] d_strb_q;
    logic [1:0]        b_resp_q;
    logic              aw_hs, w_hs;
    logic              unused_addr;

    assign unused_addr = ^aw_addr[1:0];

    always_comb begin
        // Readies drop during reset so nothing is accepted in that cycle.
        aw_ready = !rst && (state == W_IDLE || state == W_HAVE_D);
        w_ready  = !rst && (state == W_IDLE || state == W_HAVE_A);
        aw_hs    = aw_valid && aw_ready;
        w_hs     = w_valid && w_ready;
        b_valid  = (state == W_RESP);
        b_resp   = b_resp_q;

        commit = ((state == W_IDLE)   && aw_hs && w_hs) ||
                 ((state == W_HAVE_A) && w_hs) ||
                 ((state == W_HAVE_D) && aw_hs);

        // Whichever half arrived earlier comes from its latch.
        commit_req.idx  = (state == W_HAVE_A) ? a_idx_q  : aw_addr[4:2];
        commit_req.data = (state == W_HAVE_D) ? d_data_q : w_data;
        commit_req.strb = (state == W_HAVE_D) ? d_strb_q : w_strb;

        state_nxt = state;
        case (state)
            W_IDLE: begin
                if (aw_hs && w_hs) state_nxt = W_RESP;
                else if (aw_hs)    state_nxt = W_HAVE_A;
                else if (w_hs)     state_nxt = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)    state_nxt = W_RESP;
            W_HAVE_D: if (aw_hs)   state_nxt = W_RESP;
            W_RESP:   if (b_ready) state_nxt = W_IDLE;
            default:               state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= W_IDLE;
            a_idx_q  <= '0;
            d_data_q <= '0;
            d_strb_q <= '0;
            b_resp_q <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (aw_hs) a_idx_q <= aw_addr[4:2];
            if (w_hs) begin
                d_data_q <= w_data;
                d_strb_q <= w_strb;
            end
            if (commit)
                b_resp_q <= idx_decoded(commit_req.idx) ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: rtl/vid_gen_axil_regs.sv
// vid_gen_axil_regs: AXI4-Lite register bank for the vid_gen core.
//   0x00 CTRL, 0x04 HSIZE, 0x08 VSIZE, 0x0C COLOR (R/W), 0x10 STATUS (RO,
//   frame_cnt). Other offsets answer SLVERR. With VID_GEN_IRQ_EN defined,
//   0x14 IRQ_EN and 0x18 IRQ_STAT (W1C, sticky on frame_cnt change) plus an
//   irq output are added.
// Ports:
//   ACLK, ARESET       clock, synchronous active-high reset
//   S_AXI_*            AXI4-Lite slave interface
//   vid_*              control fields sliced straight from the registers
//   vid_cfg_update     one-cycle pulse alongside BVALID for an OKAY config write
//   frame_cnt          frame counter from the core
//   irq                (VID_GEN_IRQ_EN only) registered interrupt
import vid_gen_axil_pkg::*;

module vid_gen_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_FRAME_CNT_WIDTH  = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            vid_enable,
    output logic [2:0]                      vid_pattern,
    output logic [15:0]                     vid_h_active,
    output logic [15:0]                     vid_v_active,
    output logic [23:0]                     vid_color,
    output logic                            vid_cfg_update,
    input  logic [C_FRAME_CNT_WIDTH-1:0]    frame_cnt
`ifdef VID_GEN_IRQ_EN
    ,
    output logic                            irq
`endif
);

    // Four R/W config words, index = addr[3:2].
    logic [3:0][DATA_W-1:0] cfg_q;
    logic                   cfg_update_q;
    logic                   wr_commit;
    wr_commit_t             wr_req;

    rd_state_t              rd_state, rd_state_nxt;
    logic [DATA_W-1:0]      rd_data_q, rd_data_c;
    logic [1:0]             rd_resp_q, rd_resp_c;
    logic [2:0]             ar_idx;
    logic                   ar_hs;
    logic                   unused_in;

    assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

    vid_gen_axil_wr_ctrl #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_wr_ctrl (
        .clk        (ACLK),
        .rst        (ARESET),
        .aw_addr    (S_AXI_AWADDR),
        .aw_valid   (S_AXI_AWVALID),
        .aw_ready   (S_AXI_AWREADY),
        .w_data     (S_AXI_WDATA),
        .w_strb     (S_AXI_WSTRB),
        .w_valid    (S_AXI_WVALID),
        .w_ready    (S_AXI_WREADY),
        .b_resp     (S_AXI_BRESP),
        .b_valid    (S_AXI_BVALID),
        .b_ready    (S_AXI_BREADY),
        .commit     (wr_commit),
        .commit_req (wr_req)
    );

    // ---------------- config registers ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cfg_q        <= {RST_COLOR, RST_VSIZE, RST_HSIZE, RST_CTRL};
            cfg_update_q <= 1'b0;
        end else begin
            // Registered so the pulse lines up with the first BVALID cycle.
            cfg_update_q <= wr_commit && idx_cfg(wr_req.idx);
            if (wr_commit && !wr_req.idx[2]) begin
                for (int b = 0; b < STRB_W; b++)
                    if (wr_req.strb[b])
                        cfg_q[wr_req.idx[1:0]][b*8 +: 8] <= wr_req.data[b*8 +: 8];
            end
        end
    end

`ifdef VID_GEN_IRQ_EN
    logic [C_FRAME_CNT_WIDTH-1:0] frame_cnt_q;
    logic                         irq_en_q, irq_stat_q, irq_q, irq_clr;

    assign irq_clr = wr_commit && (wr_req.idx == IDX_IRQ_STAT) &&
                     wr_req.strb[0] && wr_req.data[0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            frame_cnt_q <= '0;
            irq_en_q    <= 1'b0;
            irq_stat_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt;
            if (wr_commit && (wr_req.idx == IDX_IRQ_EN) && wr_req.strb[0])
                irq_en_q <= wr_req.data[0];
            // Set beats a same-cycle clear.
            if (frame_cnt != frame_cnt_q) irq_stat_q <= 1'b1;
            else if (irq_clr)             irq_stat_q <= 1'b0;
            irq_q <= irq_en_q && irq_stat_q;
        end
    end

    assign irq = irq_q;
`endif

    // ---------------- read channel ----------------
    assign ar_idx        = S_AXI_ARADDR[4:2];
    assign S_AXI_ARREADY = !ARESET && (rd_state == R_IDLE);
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        if (!ar_idx[2])
            rd_data_c = cfg_q[ar_idx[1:0]];
        else if (ar_idx == IDX_STATUS)
            rd_data_c = DATA_W'(frame_cnt);
`ifdef VID_GEN_IRQ_EN
        else if (ar_idx == IDX_IRQ_EN)
            rd_data_c = DATA_W'(irq_en_q);
        else if (ar_idx == IDX_IRQ_STAT)
            rd_data_c = DATA_W'(irq_stat_q);
`endif
        else
            rd_resp_c = RESP_SLVERR;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)        rd_state_nxt = R_RESP;
            R_RESP:  if (S_AXI_RREADY) rd_state_nxt = R_IDLE;
            default:                   rd_state_nxt = R_IDLE;
        endcase
    end

    // Captured before any same-edge write lands, so a colliding read sees the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state  <= R_IDLE;
            rd_data_q <= '0;
            rd_resp_q <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_nxt;
            if (ar_hs) begin
                rd_data_q <= rd_data_c;
                rd_resp_q <= rd_resp_c;
            end
        end
    end

    assign S_AXI_RVALID = (rd_state == R_RESP);
    assign S_AXI_RDATA  = rd_data_q;
    assign S_AXI_RRESP  = rd_resp_q;

    // ---------------- core-facing fields ----------------
    assign vid_enable     = cfg_q[0][0];
    assign vid_pattern    = cfg_q[0][3:1];
    assign vid_h_active   = cfg_q[1][15:0];
    assign vid_v_active   = cfg_q[2][15:0];
    assign vid_color      = cfg_q[3][23:0];
    assign vid_cfg_update = cfg_update_q;

endmodule
